// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: latches an instruction, decodes it, and
// sequences EX / MEM / WB / MD phases, emitting one pc_we per instruction.
module multicycle_ctrl #(
   parameter int MD_LAT  = 32,
   parameter int MEM_TMO = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   input  logic [5:0] opcode,
   input  logic [4:0] rt,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       instr_ack,
   output logic [2:0] state,
   output logic [3:0] ALUOp,
   output logic [2:0] Loadop,
   output logic [1:0] Saveop,
   output logic       EXTOp,
   output logic       mem_re,
   output logic       mem_we,
   output logic       reg_we,
   output logic       hilo_we,
   output logic       pc_we,
   output logic       illegal
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ID   = 3'd1;
   localparam logic [2:0] S_EX   = 3'd2;
   localparam logic [2:0] S_MEM  = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_MD   = 3'd5;

   localparam logic [6:0] MD_LOAD   = 7'(MD_LAT - 1);
   localparam logic [7:0] TMO_LIMIT = 8'(MEM_TMO);
   localparam logic       TMO_EN    = (MEM_TMO > 0);

   logic [5:0] op_q;
   logic [4:0] rt_q;
   logic [5:0] funct_q;
   logic [6:0] md_cnt;
   logic [7:0] tmo_cnt;
   logic [2:0] next_state;

   logic [3:0] alu_d;
   logic [2:0] load_d;
   logic [1:0] save_d;
   logic       ext_d;

   logic is_load, is_store, is_muldiv, to_idle, to_wb;

   // Field decode of the latched instruction; captured into the outputs in ID.
   always_comb begin
      alu_d  = 4'b1111;
      load_d = 3'b111;
      save_d = 2'b11;
      ext_d  = 1'b1;
      case (op_q)
         6'h00: alu_d = (funct_q == 6'h09) ? 4'b1111 : 4'b0000;
         6'h01: alu_d = (rt_q == 5'd1) ? 4'b0010 : 4'b0101;
         6'h04: alu_d = 4'b0001;
         6'h05: alu_d = 4'b0110;
         6'h06: alu_d = 4'b0100;
         6'h07: alu_d = 4'b0011;
         6'h08, 6'h09: alu_d = 4'b1001;
         6'h0a: alu_d = 4'b1101;
         6'h0b: alu_d = 4'b1110;
         6'h0c: begin alu_d = 4'b1010; ext_d = 1'b0; end
         6'h0d: begin alu_d = 4'b1011; ext_d = 1'b0; end
         6'h0e: begin alu_d = 4'b1100; ext_d = 1'b0; end
         6'h0f: alu_d = 4'b1000;
         6'h20: begin alu_d = 4'b0111; load_d = 3'b001; end
         6'h21: begin alu_d = 4'b0111; load_d = 3'b011; end
         6'h23: begin alu_d = 4'b0111; load_d = 3'b000; end
         6'h24: begin alu_d = 4'b0111; load_d = 3'b010; end
         6'h25: begin alu_d = 4'b0111; load_d = 3'b100; end
         6'h28: begin alu_d = 4'b0111; save_d = 2'b01; end
         6'h29: begin alu_d = 4'b0111; save_d = 2'b10; end
         6'h2b: begin alu_d = 4'b0111; save_d = 2'b00; end
         default: ;
      endcase
   end

   // Instruction class drives the EX-stage routing.
   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_muldiv = 1'b0;
      to_idle   = 1'b0;
      to_wb     = 1'b0;
      case (op_q)
         6'h00: begin
            if (funct_q[5:2] == 4'b0110) is_muldiv = 1'b1;
            else if (funct_q == 6'h08)   to_idle   = 1'b1;
            else                         to_wb     = 1'b1;
         end
         6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07: to_idle = 1'b1;
         6'h03, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: to_wb = 1'b1;
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: is_load = 1'b1;
         6'h28, 6'h29, 6'h2b: is_store = 1'b1;
         default: ;
      endcase
   end

   // Next state and strobes; strobes are forced low while reset is asserted.
   always_comb begin
      next_state = state;
      instr_ack  = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      hilo_we    = 1'b0;
      pc_we      = 1'b0;
      illegal    = 1'b0;
      case (state)
         S_IDLE: begin
            if (instr_valid) begin
               instr_ack  = 1'b1;
               next_state = S_ID;
            end
         end
         S_ID: next_state = S_EX;
         S_EX: begin
            if (is_muldiv)                next_state = S_MD;
            else if (is_load || is_store) next_state = S_MEM;
            else if (to_wb)               next_state = S_WB;
            else begin
               illegal    = ~to_idle;
               pc_we      = 1'b1;
               next_state = S_IDLE;
            end
         end
         S_MEM: begin
            if (TMO_EN && (tmo_cnt == TMO_LIMIT)) begin
               illegal    = 1'b1;
               pc_we      = 1'b1;
               next_state = S_IDLE;
            end else begin
               mem_re = is_load;
               mem_we = is_store;
               if (mem_ready) begin
                  if (is_load) next_state = S_WB;
                  else begin
                     pc_we      = 1'b1;
                     next_state = S_IDLE;
                  end
               end
            end
         end
         S_WB: begin
            reg_we     = 1'b1;
            pc_we      = 1'b1;
            next_state = S_IDLE;
         end
         S_MD: begin
            if (md_cnt == 7'd0) begin
               hilo_we    = 1'b1;
               pc_we      = 1'b1;
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
      if (rst) begin
         instr_ack = 1'b0;
         mem_re    = 1'b0;
         mem_we    = 1'b0;
         reg_we    = 1'b0;
         hilo_we   = 1'b0;
         pc_we     = 1'b0;
         illegal   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         op_q    <= 6'd0;
         rt_q    <= 5'd0;
         funct_q <= 6'd0;
         ALUOp   <= 4'b1111;
         Loadop  <= 3'b111;
         Saveop  <= 2'b11;
         EXTOp   <= 1'b1;
         md_cnt  <= 7'd0;
         tmo_cnt <= 8'd0;
      end else begin
         state <= next_state;
         if (state == S_IDLE && instr_valid) begin
            op_q    <= opcode;
            rt_q    <= rt;
            funct_q <= funct;
         end
         if (state == S_ID) begin
            ALUOp  <= alu_d;
            Loadop <= load_d;
            Saveop <= save_d;
            EXTOp  <= ext_d;
         end
         if (state == S_EX) begin
            tmo_cnt <= 8'd0;
            if (is_muldiv) md_cnt <= MD_LOAD;
         end
         if (state == S_MD && md_cnt != 7'd0) md_cnt <= md_cnt - 7'd1;
         if (state == S_MEM && !mem_ready && tmo_cnt != 8'hff) tmo_cnt <= tmo_cnt + 8'd1;
      end
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MD_LAT, default 32: multiply/divide busy cycles, legal range 1..64.
REQ-002 SHALL have parameter MEM_TMO, default 0: maximum MEM wait cycles, 0 = no timeout, legal range 0..255.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port instr_valid  in  1  fetch presents an instruction.
REQ-006 SHALL have port opcode  in  6  instruction bits [31:26].
REQ-007 SHALL have port rt  in  5  instruction bits [20:16].
REQ-008 SHALL have port funct  in  6  instruction bits [5:0].
REQ-009 SHALL have port mem_ready  in  1  memory completes the current access.
REQ-010 SHALL have port instr_ack  out  1  one-cycle pulse: instruction accepted.
REQ-011 SHALL have port state  out  3  current state encoding.
REQ-012 SHALL have port ALUOp  out  4  registered ALU operation.
REQ-013 SHALL have port Loadop  out  3  registered load width code.
REQ-014 SHALL have port Saveop  out  2  registered store width code.
REQ-015 SHALL have port EXTOp  out  1  1 = sign-extend, 0 = zero-extend.
REQ-016 SHALL have ports mem_re and mem_we  out  1 each  memory read and write strobes.
REQ-017 SHALL have ports reg_we and hilo_we  out  1 each  register-file and HI/LO write strobes.
REQ-018 SHALL have port pc_we  out  1  PC update strobe.
REQ-019 SHALL have port illegal  out  1  one-cycle pulse: unknown opcode or MEM timeout.

Function
REQ-020 SHALL encode states as IDLE=0, ID=1, EX=2, MEM=3, WB=4, MD=5.
REQ-021 SHALL, in IDLE with instr_valid=1: latch opcode, rt and funct; pulse instr_ack; go to ID. instr_valid is ignored in every other state.
REQ-022 SHALL, in ID, decode the latched fields into ALUOp, Loadop, Saveop and EXTOp, and hold those values until the next ID.
REQ-023 SHALL use ALUOp codes: R-type 0000; JALR 1111; BEQ 0001; REGIMM with rt=00001 0010, with any other rt 0101; BGTZ 0011; BLEZ 0100; BNE 0110; load/store 0111; LUI 1000; ADDI/ADDIU 1001; ANDI 1010; ORI 1011; XORI 1100; SLTI 1101; SLTIU 1110; any other opcode 1111.
REQ-024 SHALL use Loadop codes LW=000, LB=001, LBU=010, LH=011, LHU=100, other=111; Saveop codes SW=00, SB=01, SH=10, other=11; EXTOp=0 only for ANDI, ORI and XORI.
REQ-025 SHALL take the following transition out of EX:
- opcode 0 with funct 011000..011011 (MULT/MULTU/DIV/DIVU): to MD, load counter with MD_LAT-1.
- load or store: to MEM.
- branch, J or JR: to IDLE.
- JAL, JALR, other R-type or ALU-immediate: to WB.
- unknown opcode: to IDLE and pulse illegal.
REQ-026 SHALL, in MD, decrement the counter each cycle; at counter=0 pulse hilo_we and go to IDLE. Total MD residency is MD_LAT cycles.
REQ-027 SHALL, in MEM, hold mem_re (load) or mem_we (store) high until a cycle with mem_ready=1; in that cycle a store goes to IDLE and a load goes to WB.
REQ-028 SHALL, when MEM_TMO>0 and MEM_TMO cycles elapse with mem_ready=0, drop the strobe, pulse illegal and go to IDLE.
REQ-029 SHALL, in WB, pulse reg_we for one cycle and go to IDLE.
REQ-030 SHALL pulse pc_we exactly once per accepted instruction, in its final cycle (the cycle that transitions to IDLE), including the illegal and timeout cases.
REQ-031 SHALL treat mem_ready outside MEM as don't-care; mem_ready=1 in the first MEM cycle gives one-cycle MEM residency.
REQ-032 SHALL keep all strobes (instr_ack, mem_re, mem_we, reg_we, hilo_we, pc_we, illegal) low except as specified above.
REQ-033 SHALL give minimum latencies, counted from the instr_ack cycle to the pc_we cycle inclusive: branch 3; ALU 4; store 4; load 5; muldiv 3+MD_LAT.

Reset
REQ-034 SHALL, with rst=1 at a rising edge in any state, go to IDLE on that edge, overriding all transitions and aborting any in-flight instruction without pc_we.
REQ-035 SHALL reset outputs to: state=0; ALUOp=1111; Loadop=111; Saveop=11; EXTOp=1; all strobes 0; MD counter and MEM timeout counter 0.

Verification
REQ-036 SHALL cover ADDU (opcode 0, funct 100001): instr_ack at t, reg_we and pc_we at t+3, ALUOp=0000.
REQ-037 SHALL cover LW (100011) with mem_ready after 2 wait cycles: mem_re high 3 cycles, Loadop=000, then reg_we; pc_we at t+6.
REQ-038 SHALL cover MULT (funct 011000) with MD_LAT=4: MD occupied 4 cycles, hilo_we and pc_we together at t+6, reg_we never set.
REQ-039 SHALL cover BGEZ (opcode 000001, rt=00001): ALUOp=0010, pc_we at t+2, no reg_we, mem_re or mem_we.
REQ-040 SHALL cover SW with MEM_TMO=3 and mem_ready held 0: mem_we high 3 cycles, then illegal and pc_we pulse together, state returns to 0.
REQ-041 SHALL cover rst asserted during MD: state=0 on the next edge, ALUOp=1111, no hilo_we or pc_we.
